// File: rtl/dvb_s2_enc_frame_sched.sv
// ============================================================================
// Module  : dvb_s2_enc_frame_sched
// Brief   : Round-robin BBFRAME scheduler sharing the encoder AXIS byte input.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dvb_s2_enc_frame_sched #(
    parameter int pN_REQ = 4,
    parameter int pLEN_W = 13,
    parameter int pACM_W = 9
) (
    input  logic                     iclk,
    input  logic                     ireset,
    input  logic [pN_REQ-1:0]        ireq,
    input  logic [pN_REQ*pACM_W-1:0] ireq_acm,
    input  logic [pN_REQ*pLEN_W-1:0] ireq_len,
    output logic [pN_REQ-1:0]        oack,
    input  logic [pN_REQ-1:0]        ival,
    input  logic [pN_REQ*8-1:0]      idat,
    output logic [pN_REQ-1:0]        ordy,
    input  logic                     ienc_busy,
    output logic                     m_axis_tvalid,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tlast,
    output logic [7:0]               m_axis_tid,
    output logic [pACM_W-1:0]        m_axis_tuser,
    input  logic                     m_axis_tready,
    output logic                     obusy,
    output logic                     oframe_done,
    output logic                     olen_err
);

    localparam int IDX_W = (pN_REQ > 1) ? $clog2(pN_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [pLEN_W-1:0]   len_q, len_d;
    logic [pLEN_W-1:0]   cnt_q, cnt_d;
    logic [pACM_W-1:0]   acm_q, acm_d;
    logic [pN_REQ-1:0]   ack_q, ack_d;
    logic                done_q, done_d;
    logic                lerr_q, lerr_d;

    logic                w_found;
    logic [IDX_W-1:0]    w_pick;
    logic [IDX_W-1:0]    w_idx;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic                w_xfer;
    logic                w_last;
    logic                w_hs;

    // First pending request at or after the priority pointer, wrapping modulo pN_REQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = ptr_q;
        w_idx   = '0;
        for (int i = 0; i < pN_REQ; i++) begin
            w_idx = IDX_W'((int'(ptr_q) + i) % pN_REQ);
            if (!w_found && ireq[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_ptr_nxt = (sel_q == IDX_W'(pN_REQ - 1)) ? '0 : sel_q + IDX_W'(1);
    assign w_xfer    = (state_q == ST_XFER);
    assign w_last    = (cnt_q == len_q - pLEN_W'(1));
    assign w_hs      = m_axis_tvalid & m_axis_tready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        len_d   = len_q;
        acm_d   = acm_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        done_d  = 1'b0;
        lerr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!ienc_busy && w_found) begin
                    sel_d         = w_pick;
                    len_d         = ireq_len[w_pick*pLEN_W +: pLEN_W];
                    acm_d         = ireq_acm[w_pick*pACM_W +: pACM_W];
                    ack_d[w_pick] = 1'b1;
                    state_d       = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (len_q == '0) begin
                    lerr_d  = 1'b1;
                    ptr_d   = w_ptr_nxt;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_hs) begin
                    cnt_d = cnt_q + pLEN_W'(1);
                    if (w_last) begin
                        done_d  = 1'b1;
                        ptr_d   = w_ptr_nxt;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            len_q   <= '0;
            acm_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            done_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            acm_q   <= acm_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            lerr_q  <= lerr_d;
        end
    end

    // Byte path is a pure pass-through from the granted requester during XFER.
    always_comb begin
        ordy = '0;
        if (w_xfer) begin
            ordy[sel_q] = m_axis_tready;
        end
    end

    assign m_axis_tvalid = w_xfer & ival[sel_q];
    assign m_axis_tdata  = w_xfer ? idat[sel_q*8 +: 8] : 8'd0;
    assign m_axis_tlast  = w_xfer & w_last;
    assign m_axis_tid    = (state_q != ST_IDLE) ? 8'(sel_q) : 8'd0;
    assign m_axis_tuser  = (state_q != ST_IDLE) ? acm_q : '0;
    assign obusy         = (state_q != ST_IDLE);
    assign oack          = ack_q;
    assign oframe_done   = done_q;
    assign olen_err      = lerr_q;

endmodule

`default_nettype wire

// File: tb/tb_dvb_s2_enc_frame_sched.sv
// ============================================================================
// Module  : tb_dvb_s2_enc_frame_sched
// Brief   : Scoreboard bench for the round-robin frame scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dvb_s2_enc_frame_sched;

    localparam int N  = 4;
    localparam int LW = 13;
    localparam int AW = 9;

    logic              clk = 1'b0;
    logic              ireset;
    logic [N-1:0]      ireq;
    logic [N*AW-1:0]   ireq_acm;
    logic [N*LW-1:0]   ireq_len;
    logic [N-1:0]      oack;
    logic [N-1:0]      ival;
    logic [N*8-1:0]    idat;
    logic [N-1:0]      ordy;
    logic              ienc_busy;
    logic              tvalid;
    logic [7:0]        tdata;
    logic              tlast;
    logic [7:0]        tid;
    logic [AW-1:0]     tuser;
    logic              tready;
    logic              obusy;
    logic              oframe_done;
    logic              olen_err;

    always #5 clk = ~clk;

    dvb_s2_enc_frame_sched #(.pN_REQ(N), .pLEN_W(LW), .pACM_W(AW)) dut (
        .iclk(clk), .ireset(ireset), .ireq(ireq), .ireq_acm(ireq_acm),
        .ireq_len(ireq_len), .oack(oack), .ival(ival), .idat(idat), .ordy(ordy),
        .ienc_busy(ienc_busy), .m_axis_tvalid(tvalid), .m_axis_tdata(tdata),
        .m_axis_tlast(tlast), .m_axis_tid(tid), .m_axis_tuser(tuser),
        .m_axis_tready(tready), .obusy(obusy), .oframe_done(oframe_done),
        .olen_err(olen_err)
    );

    typedef struct packed {
        logic [7:0]    tid;
        logic [AW-1:0] tuser;
        logic [7:0]    data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [7:0]    idx;
        logic [LW-1:0] len;
    } grant_t;

    beat_t  exp_beats[$];
    grant_t exp_grant[$];
    int     checks = 0;
    int     failures = 0;

    logic [7:0] src_mem[N][64];
    int         src_rd[N];
    int         src_wr[N];
    int         lens_m[N];
    int         acm_m[N];
    int         ptr_m = 0;
    int         rdy_mode = 2;
    bit         val_all = 1'b1;
    bit         rand_busy = 1'b0;

    logic [N-1:0] hs = '0;
    bit           prev_stall = 1'b0;
    logic [7:0]   prev_data = '0;
    logic         prev_last = 1'b0;
    bit           prev_last_hs = 1'b0;
    bit           exp_err_next = 1'b0;
    bit           exp_done_next = 1'b0;
    logic         busy_prev = 1'b0;

    task automatic chk(input string name, input bit ok, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: everything observable is compared against queued expectations.
    always @(negedge clk) begin
        beat_t        b;
        grant_t       g;
        logic [N-1:0] ev;
        if (ireset) begin
            prev_stall    = 1'b0;
            prev_last_hs  = 1'b0;
            exp_err_next  = 1'b0;
            exp_done_next = 1'b0;
            busy_prev     = 1'b0;
            hs            = '0;
        end else begin
            hs = ival & ordy;
            if (prev_stall)
                chk("stall_stable", tvalid && tdata == prev_data && tlast == prev_last,
                    {tvalid, tdata, tlast}, {1'b1, prev_data, prev_last});
            if (prev_last_hs)
                chk("gap_after_last", !tvalid, 64'(tvalid), 64'd0);
            if (olen_err || exp_err_next)
                chk("olen_err", olen_err == exp_err_next, 64'(olen_err), 64'(exp_err_next));
            if (oframe_done || exp_done_next)
                chk("frame_done", oframe_done == exp_done_next, 64'(oframe_done),
                    64'(exp_done_next));
            exp_err_next  = 1'b0;
            exp_done_next = 1'b0;
            if (oack != '0) begin
                if (exp_grant.size() == 0) begin
                    chk("grant_unexpected", 1'b0, 64'(oack), 64'd0);
                end else begin
                    g  = exp_grant.pop_front();
                    ev = '0;
                    ev[g.idx[1:0]] = 1'b1;
                    chk("grant", oack == ev && !busy_prev, {busy_prev, oack}, 64'(ev));
                    if (g.len == '0) exp_err_next = 1'b1;
                end
            end
            if (tvalid) begin
                ev = '0;
                ev[tid[1:0]] = tready;
                chk("ordy", ordy == ev, 64'(ordy), 64'(ev));
            end
            if (tvalid && tready) begin
                if (exp_beats.size() == 0) begin
                    chk("beat_unexpected", 1'b0, {tid, tuser, tdata, tlast}, 64'd0);
                end else begin
                    b = exp_beats.pop_front();
                    chk("beat", tdata == b.data && tlast == b.last && tid == b.tid &&
                        tuser == b.tuser, {tid, tuser, tdata, tlast}, 64'(b));
                    if (b.last) exp_done_next = 1'b1;
                end
            end
            if (!obusy)
                chk("idle_outs", !tvalid && tid == 0 && tuser == 0 && ordy == 0,
                    {tvalid, tid, tuser, ordy}, 64'd0);
            prev_stall   = tvalid && !tready;
            prev_data    = tdata;
            prev_last    = tlast;
            prev_last_hs = tvalid && tready && tlast;
            busy_prev    = ienc_busy;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (oack[k]) ireq[k] = 1'b0;
            if (hs[k] && src_rd[k] < src_wr[k]) src_rd[k]++;
            if (src_rd[k] >= src_wr[k]) begin
                ival[k] = 1'b0;
            end else begin
                if (!(ival[k] && !hs[k]))
                    ival[k] = val_all ? 1'b1 : ($urandom_range(0, 3) != 0);
                idat[k*8 +: 8] = src_mem[k][src_rd[k]];
            end
        end
        case (rdy_mode)
            0:       tready = ($urandom_range(0, 2) != 0);
            1:       tready = ~tready;
            default: tready = 1'b1;
        endcase
        if (rand_busy) ienc_busy = ($urandom_range(0, 3) == 0);
    endtask

    // Reference: requesters posted together are served in cyclic order from ptr.
    task automatic post_round(input logic [N-1:0] mask, output int first);
        int   last_k;
        logic [7:0] d;
        first  = -1;
        last_k = 0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr_m + i) % N;
            if (mask[k]) begin
                if (first < 0) first = k;
                last_k    = k;
                src_rd[k] = 0;
                src_wr[k] = 0;
                exp_grant.push_back('{idx: 8'(k), len: LW'(lens_m[k])});
                for (int b = 0; b < lens_m[k]; b++) begin
                    d = 8'($urandom);
                    src_mem[k][src_wr[k]] = d;
                    src_wr[k]++;
                    exp_beats.push_back('{tid: 8'(k), tuser: AW'(acm_m[k]), data: d,
                                          last: (b == lens_m[k] - 1)});
                end
            end
        end
        if (mask != '0) ptr_m = (last_k + 1) % N;
        for (int k = 0; k < N; k++) begin
            ireq_acm[k*AW +: AW] = AW'(acm_m[k]);
            ireq_len[k*LW +: LW] = LW'(lens_m[k]);
        end
    endtask

    task automatic run_round(input logic [N-1:0] mask, input int rmode, input bit vall,
                             input int busy_hold, input bit chk_first, input bit rbusy);
        int first;
        int guard;
        logic [N-1:0] ev;
        rdy_mode = rmode;
        val_all  = vall;
        post_round(mask, first);
        if (busy_hold > 0) ienc_busy = 1'b1;
        ireq = mask;
        for (int c = 0; c < busy_hold; c++) begin
            step();
            chk("busy_gate", oack == '0, 64'(oack), 64'd0);
        end
        ienc_busy = 1'b0;
        rand_busy = rbusy;
        if (chk_first) begin
            step();
            ev = '0;
            ev[first] = 1'b1;
            chk("first_ack", oack == ev, 64'(oack), 64'(ev));
        end
        guard = 0;
        while ((exp_grant.size() != 0 || exp_beats.size() != 0 || obusy) && guard < 3000) begin
            step();
            guard++;
        end
        if (guard >= 3000) begin
            chk("round_timeout", 1'b0, 64'(exp_beats.size()), 64'd0);
            exp_grant.delete();
            exp_beats.delete();
        end
        rand_busy = 1'b0;
        ienc_busy = 1'b0;
        step();
        step();
    endtask

    function automatic bit all_zero();
        return oack == 0 && ordy == 0 && !tvalid && tdata == 0 && !tlast && tid == 0 &&
               tuser == 0 && !obusy && !oframe_done && !olen_err;
    endfunction

    initial begin
        int first;
        int guard;
        ireset = 1'b1; ireq = '0; ireq_acm = '0; ireq_len = '0; ival = '0; idat = '0;
        ienc_busy = 1'b0; tready = 1'b0;
        for (int k = 0; k < N; k++) begin
            src_rd[k] = 0; src_wr[k] = 0; lens_m[k] = 1; acm_m[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", all_zero(), {oack, ordy, tvalid, tid}, 64'd0);
        ireset = 1'b0;
        step();

        // Single requester
        lens_m[0] = 5; acm_m[0] = 20;
        run_round(4'b0001, 2, 1'b1, 0, 1'b1, 1'b0);

        // Round robin over all four, then wrap
        for (int k = 0; k < N; k++) begin lens_m[k] = 3; acm_m[k] = 100 + k; end
        run_round(4'b1111, 2, 1'b1, 0, 1'b1, 1'b0);
        run_round(4'b1111, 0, 1'b0, 0, 1'b1, 1'b0);

        // Backpressure with toggling tready
        lens_m[1] = 8; acm_m[1] = 9'h1a5;
        run_round(4'b0010, 1, 1'b1, 0, 1'b1, 1'b0);

        // Zero length then pointer must sit just past it
        lens_m[2] = 0; acm_m[2] = 7;
        run_round(4'b0100, 2, 1'b1, 0, 1'b1, 1'b0);
        lens_m[0] = 2; lens_m[3] = 2;
        run_round(4'b1001, 2, 1'b1, 0, 1'b1, 1'b0);

        // Busy gate
        lens_m[1] = 4;
        run_round(4'b0010, 2, 1'b1, 5, 1'b1, 1'b0);

        // Reset mid-frame: ptr is non-zero beforehand
        lens_m[0] = 10; acm_m[0] = 33;
        rdy_mode = 2; val_all = 1'b1;
        post_round(4'b0001, first);
        ireq = 4'b0001;
        guard = 0;
        while (exp_beats.size() > 7 && guard < 200) begin
            step();
            guard++;
        end
        chk("reset_setup", guard < 200, 64'(exp_beats.size()), 64'd7);
        ireset = 1'b1;
        @(posedge clk);
        #1;
        chk("midframe_reset", all_zero(), {oack, ordy, tvalid, tlast, obusy}, 64'd0);
        ireset = 1'b0;
        exp_beats.delete();
        exp_grant.delete();
        ireq = '0; ival = '0;
        for (int k = 0; k < N; k++) begin src_rd[k] = 0; src_wr[k] = 0; end
        ptr_m = 0;
        lens_m[0] = 4; lens_m[3] = 3;
        run_round(4'b1001, 2, 1'b1, 0, 1'b1, 1'b0);

        // Randomised rounds
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < N; k++) begin
                lens_m[k] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
                acm_m[k]  = $urandom_range(0, 511);
            end
            run_round(4'($urandom_range(1, 15)), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), 0, 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
